// File: rtl/rv16_pkg.sv
// Shared core-wide widths and the writeback request record.
package rv16_pkg;
   localparam int XLEN     = 16;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; head is visible combinationally.
module wb_fifo
   import rv16_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_req_t         mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // Storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU results against buffered load returns
// onto the register-file write port and tracks registers awaiting load data.
module writeback_unit
   import rv16_pkg::*;
#(
   parameter int LD_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid,
   input  logic [REG_AW-1:0]   alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   output logic                alu_stall,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [REG_AW-1:0]   ld_rd,
   input  logic [XLEN-1:0]     ld_data,
   input  logic                issue_ld,
   input  logic [REG_AW-1:0]   issue_rd,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic                we,
   output logic [REG_AW-1:0]   wr_addr,
   output logic [XLEN-1:0]     wr_data
);
   localparam int AW = $clog2(STARVE_MAX + 1);

   wb_req_t             head;
   logic                full, empty;
   logic                alu_xfer, ld_push, ld_pop;
   logic [AW-1:0]       age_q, age_d;
   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic                we_q, we_d;
   logic [REG_AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     data_q, data_d;

   assign ld_ready  = !rst && !full;
   assign alu_stall = !rst && !empty && (age_q >= AW'(STARVE_MAX));
   assign alu_xfer  = alu_valid && !alu_stall;
   assign ld_push   = ld_valid && ld_ready;
   assign ld_pop    = !rst && !alu_xfer && !empty;

   wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (ld_push),
      .push_req ('{rd: ld_rd, data: ld_data}),
      .pop      (ld_pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      we_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
      if (alu_xfer) begin
         we_d   = (alu_rd != '0);
         addr_d = alu_rd;
         data_d = alu_data;
      end else if (ld_pop) begin
         we_d   = (head.rd != '0);
         addr_d = head.rd;
         data_d = head.data;
      end
   end

   always_comb begin
      age_d = age_q;
      if (empty || ld_pop) begin
         age_d = '0;
      end else if (age_q < AW'(STARVE_MAX)) begin
         age_d = age_q + AW'(1);
      end
   end

   // Set is applied after clear so a same-cycle issue to the popped register wins.
   always_comb begin
      pend_d = pend_q;
      if (ld_pop) pend_d[head.rd] = 1'b0;
      if (issue_ld && issue_rd != '0) pend_d[issue_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         age_q  <= '0;
         pend_q <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         age_q  <= age_d;
         pend_q <= pend_d;
      end
   end

   assign we           = we_q;
   assign wr_addr      = addr_q;
   assign wr_data      = data_q;
   assign pending_mask = pend_q;
endmodule
